// File: rtl/stream_pkg.sv
// Shared types and helpers for the byte-stream source/sink pair.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package stream_pkg;

    // Largest supported message. Messages are carried right-aligned in a
    // vector of this width so one helper serves every MSG_LEN.
    localparam int MSG_MAX_LEN  = 255;
    localparam int MSG_MAX_BITS = 8 * MSG_MAX_LEN;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_DATA  = 2'd1,
        ERR_SHORT = 2'd2,
        ERR_LONG  = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_REPORT = 2'd2
    } sink_state_t;

    // Byte i of a len-byte packed message. Byte 0 is the most significant
    // byte, i.e. the first character of a string literal. Out-of-range
    // indices return 0 so callers may probe one past the end safely.
    function automatic logic [7:0] msg_byte(
        input logic [MSG_MAX_BITS-1:0] msg,
        input int                      len,
        input int                      i
    );
        logic [7:0] b;
        b = 8'h00;
        if (i >= 0 && i < len) begin
            b = msg[8*(len-1-i) +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/tready_throttle.sv
// Periodic ready throttle: free-running counter that requests one stall cycle in every STALL_PERIOD.
// Latency: stall_nxt_o is the stall value for the cycle after the coming clock edge, for registered ready.
// Backpressure: none of its own; STALL_PERIOD=0 never stalls, STALL_PERIOD=1 is rejected at elaboration.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (counter cleared to 0)
//   stall_nxt_o high when the counter will sit at STALL_PERIOD-1 next cycle
module tready_throttle #(
    parameter int STALL_PERIOD = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic stall_nxt_o
);

    // Period 1 would hold ready low forever and deadlock the stream.
    if (STALL_PERIOD == 1 || STALL_PERIOD < 0) begin : g_bad_period
        $error("tready_throttle: STALL_PERIOD must be 0 or >= 2");
    end

    localparam int             CW   = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = (STALL_PERIOD >= 2) ? CW'(STALL_PERIOD - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With throttling disabled the counter is pinned at zero.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (STALL_PERIOD == 0 || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // Looking at cnt_d lets the consumer register ready while keeping the
    // stall aligned with cnt_q == STALL_PERIOD-1.
    assign stall_nxt_o = (STALL_PERIOD != 0) && (cnt_d == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_sink.sv
// AXI-Stream byte sink: checks each frame against a fixed MESSAGE and length, reports a verdict and counts.
// Latency: tlast accepted in cycle T -> verdict pulse/code in T+1, tready high again in T+2.
// Backpressure: tready registered; low in the single REPORT cycle after each frame and on throttle stalls.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   tvalid/tready/tlast/tdata   AXI-Stream slave (8-bit payload)
//   frame_ok, frame_err         one-cycle verdict pulses
//   err_code, err_idx           verdict of the last frame and error location, held until next frame
//   good_count, bad_count       saturating frame counters
module data_sink
    import stream_pkg::*;
#(
    parameter int                 MSG_LEN      = 11,
    parameter logic [8*MSG_LEN-1:0] MESSAGE    = "HE11O WORLD",
    parameter int                 STALL_PERIOD = 0,
    parameter int                 CNT_W        = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tvalid,
    output logic             tready,
    input  logic             tlast,
    input  logic [7:0]       tdata,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [7:0]       err_idx,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] bad_count
);

    if (MSG_LEN < 1 || MSG_LEN > MSG_MAX_LEN) begin : g_bad_len
        $error("data_sink: MSG_LEN must be in 1..255");
    end

    localparam logic [MSG_MAX_BITS-1:0] MSG_PAD = MSG_MAX_BITS'(MESSAGE);
    localparam logic [7:0]              LEN8    = 8'(MSG_LEN);
    localparam logic [8:0]              LEN9    = 9'(MSG_LEN);

    sink_state_t     state_q, state_d;
    logic [7:0]      idx_q;
    logic [7:0]      mis_idx_q;
    logic            data_bad_q;
    logic            long_flag_q;
    logic            tready_q;
    logic            frame_ok_q;
    logic            frame_err_q;
    err_code_t       err_code_q;
    logic [7:0]      err_idx_q;
    logic [CNT_W-1:0] good_q;
    logic [CNT_W-1:0] bad_q;

    logic            stall_nxt;
    logic            accept;
    logic            in_msg;
    logic [7:0]      exp_byte;
    logic            beat_mis;
    logic [8:0]      beats;
    err_code_t       verdict;
    logic [7:0]      verdict_idx;

    tready_throttle #(
        .STALL_PERIOD(STALL_PERIOD)
    ) u_throttle (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .stall_nxt_o(stall_nxt)
    );

    assign accept   = tvalid & tready_q;
    assign in_msg   = (idx_q < LEN8);
    assign exp_byte = msg_byte(MSG_PAD, MSG_LEN, int'(idx_q));
    assign beat_mis = accept & in_msg & (tdata != exp_byte);
    // Beats in the frame counting the current one; 9 bits because idx can
    // reach 255 on a long frame.
    assign beats    = {1'b0, idx_q} + 9'd1;

    // Verdict for the beat currently presented, used only when it carries
    // tlast. Length errors win over data errors. Since idx saturates at
    // MSG_LEN, "more beats than MSG_LEN" is exactly "idx already at MSG_LEN".
    always_comb begin
        verdict     = ERR_NONE;
        verdict_idx = 8'h00;
        if (long_flag_q || !in_msg) begin
            verdict     = ERR_LONG;
            verdict_idx = LEN8;
        end else if (beats < LEN9) begin
            verdict     = ERR_SHORT;
            verdict_idx = beats[7:0];
        end else if (data_bad_q || beat_mis) begin
            verdict     = ERR_DATA;
            verdict_idx = data_bad_q ? mis_idx_q : idx_q;
        end
    end

    // Next state is needed ahead of the edge so tready can be registered
    // and still drop in exactly the REPORT cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = tlast ? ST_REPORT : ST_RECV;
            ST_RECV:   if (accept && tlast) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            tready_q    <= 1'b0;
            idx_q       <= 8'h00;
            mis_idx_q   <= 8'h00;
            data_bad_q  <= 1'b0;
            long_flag_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_idx_q   <= 8'h00;
            good_q      <= '0;
            bad_q       <= '0;
        end else begin
            state_q     <= state_d;
            tready_q    <= (state_d != ST_REPORT) && !stall_nxt;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q == ST_REPORT) begin
                // Frame fully reported: start the next one clean.
                idx_q       <= 8'h00;
                mis_idx_q   <= 8'h00;
                data_bad_q  <= 1'b0;
                long_flag_q <= 1'b0;
            end else if (accept) begin
                if (in_msg) begin
                    idx_q <= idx_q + 8'd1;
                    // Only the first mismatch position is kept.
                    if (beat_mis && !data_bad_q) begin
                        data_bad_q <= 1'b1;
                        mis_idx_q  <= idx_q;
                    end
                end else begin
                    long_flag_q <= 1'b1;
                end

                if (tlast) begin
                    err_code_q <= verdict;
                    err_idx_q  <= verdict_idx;
                    if (verdict == ERR_NONE) begin
                        frame_ok_q <= 1'b1;
                        if (good_q != '1) good_q <= good_q + 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                        if (bad_q != '1) bad_q <= bad_q + 1'b1;
                    end
                end
            end
        end
    end

    assign tready     = tready_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign err_idx    = err_idx_q;
    assign good_count = good_q;
    assign bad_count  = bad_q;

endmodule

// File: tb/tb_data_sink.sv
module tb_data_sink;

    logic        clk = 1'b0;
    logic        resetn;

    // Unthrottled sink
    logic        tvalid, tlast, tready;
    logic [7:0]  tdata;
    logic        frame_ok, frame_err;
    logic [1:0]  err_code;
    logic [7:0]  err_idx;
    logic [15:0] good_count, bad_count;

    // Throttled sink (STALL_PERIOD=4)
    logic        s_tvalid, s_tlast, s_tready;
    logic [7:0]  s_tdata;
    logic        s_frame_ok, s_frame_err;
    logic [1:0]  s_err_code;
    logic [7:0]  s_err_idx;
    logic [15:0] s_good_count, s_bad_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] frame_buf [0:15];
    int         frame_len;
    int         beats_acc;
    int         cycles;
    int         s_lows;

    always #4 clk = ~clk;

    data_sink #(.MSG_LEN(11), .MESSAGE("HE11O WORLD"), .STALL_PERIOD(0), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .tdata(tdata), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .err_idx(err_idx), .good_count(good_count), .bad_count(bad_count)
    );

    data_sink #(.MSG_LEN(11), .MESSAGE("HE11O WORLD"), .STALL_PERIOD(4), .CNT_W(16)) dut_s (
        .clk(clk), .resetn(resetn), .tvalid(s_tvalid), .tready(s_tready), .tlast(s_tlast),
        .tdata(s_tdata), .frame_ok(s_frame_ok), .frame_err(s_frame_err), .err_code(s_err_code),
        .err_idx(s_err_idx), .good_count(s_good_count), .bad_count(s_bad_count)
    );

    task automatic load(input string s);
        frame_len = s.len();
        for (int i = 0; i < s.len(); i++) frame_buf[i] = s[i];
    endtask

    // Present the first n bytes of frame_buf with tvalid held high, advancing
    // only on accepted beats. Returns at #1 after the edge that accepted the
    // last byte, i.e. in the REPORT cycle when with_last is set.
    task automatic send(input bit sel, input int n, input bit with_last);
        int   k        = 0;
        int   guard    = 0;
        int   last_low = -1;
        logic acc;
        s_lows = 0;
        while (k < n && guard < 200) begin
            if (sel) begin
                s_tvalid = 1'b1;
                s_tdata  = frame_buf[k];
                s_tlast  = with_last && (k == n - 1);
                acc      = s_tready;
                if (!s_tready) begin
                    if (last_low >= 0) begin
                        vectors++;
                        if (guard - last_low != 4) begin
                            miscompares++;
                            $display("FAIL stall_gap: got %0d cycles between stalls, want 4", guard - last_low);
                        end
                    end
                    last_low = guard;
                    s_lows++;
                end
            end else begin
                tvalid = 1'b1;
                tdata  = frame_buf[k];
                tlast  = with_last && (k == n - 1);
                acc    = tready;
            end
            @(posedge clk);
            #1;
            if (acc) k++;
            guard++;
        end
        beats_acc = k;
        cycles    = guard;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = 8'h00;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
        #20;
        vectors++; if (tready !== 1'b0)       begin miscompares++; $display("FAIL rst_tready: got %b want 0", tready); end
        vectors++; if (s_tready !== 1'b0)     begin miscompares++; $display("FAIL rst_s_tready: got %b want 0", s_tready); end
        vectors++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_pulses: got %b%b want 00", frame_ok, frame_err); end
        vectors++; if (err_code !== 2'd0 || err_idx !== 8'd0) begin miscompares++; $display("FAIL rst_err: got %0d/%0d want 0/0", err_code, err_idx); end
        vectors++; if (good_count !== 16'd0 || bad_count !== 16'd0) begin miscompares++; $display("FAIL rst_counts: got %0d/%0d want 0/0", good_count, bad_count); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        vectors++; if (tready !== 1'b1) begin miscompares++; $display("FAIL post_rst_tready: got %b want 1", tready); end
    endtask

    task automatic test_good_frame;
        load("HE11O WORLD");
        send(0, frame_len, 1);
        vectors++; if (beats_acc !== 11 || cycles !== 11) begin miscompares++; $display("FAIL good_beats: got %0d beats in %0d cycles want 11/11", beats_acc, cycles); end
        vectors++; if (frame_ok !== 1'b1 || frame_err !== 1'b0) begin miscompares++; $display("FAIL good_pulse: got ok=%b err=%b want 1/0", frame_ok, frame_err); end
        vectors++; if (good_count !== 16'd1 || bad_count !== 16'd0) begin miscompares++; $display("FAIL good_counts: got %0d/%0d want 1/0", good_count, bad_count); end
        vectors++; if (err_code !== 2'd0) begin miscompares++; $display("FAIL good_code: got %0d want 0", err_code); end
        vectors++; if (tready !== 1'b0) begin miscompares++; $display("FAIL report_tready: got %b want 0", tready); end
        @(posedge clk); #1;
        vectors++; if (frame_ok !== 1'b0) begin miscompares++; $display("FAIL pulse_width: got %b want 0", frame_ok); end
        vectors++; if (tready !== 1'b1) begin miscompares++; $display("FAIL bubble_len: got tready %b want 1", tready); end
    endtask

    task automatic test_back_to_back;
        // Two frames with no idle gap; the only lost cycle is the REPORT bubble.
        load("HE11O WORLD");
        send(0, frame_len, 1);
        vectors++; if (frame_ok !== 1'b1 || good_count !== 16'd2) begin miscompares++; $display("FAIL b2b_first: got ok=%b good=%0d want 1/2", frame_ok, good_count); end
        send(0, frame_len, 1);
        vectors++; if (cycles !== 12) begin miscompares++; $display("FAIL b2b_bubble: got %0d cycles want 12", cycles); end
        vectors++; if (frame_ok !== 1'b1 || good_count !== 16'd3) begin miscompares++; $display("FAIL b2b_second: got ok=%b good=%0d want 1/3", frame_ok, good_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_data_err;
        load("HE110 WORLD");
        send(0, frame_len, 1);
        vectors++; if (frame_err !== 1'b1 || frame_ok !== 1'b0) begin miscompares++; $display("FAIL data_pulse: got ok=%b err=%b want 0/1", frame_ok, frame_err); end
        vectors++; if (err_code !== 2'd1 || err_idx !== 8'd4) begin miscompares++; $display("FAIL data_code: got %0d/%0d want 1/4", err_code, err_idx); end
        vectors++; if (bad_count !== 16'd1 || good_count !== 16'd3) begin miscompares++; $display("FAIL data_counts: got bad=%0d good=%0d want 1/3", bad_count, good_count); end
        @(posedge clk); #1;
        vectors++; if (frame_err !== 1'b0 || err_code !== 2'd1) begin miscompares++; $display("FAIL data_hold: got err=%b code=%0d want 0/1", frame_err, err_code); end
    endtask

    task automatic test_short;
        load("HE11O");
        send(0, frame_len, 1);
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL short_pulse: got %b want 1", frame_err); end
        vectors++; if (err_code !== 2'd2 || err_idx !== 8'd5) begin miscompares++; $display("FAIL short_code: got %0d/%0d want 2/5", err_code, err_idx); end
        vectors++; if (bad_count !== 16'd2) begin miscompares++; $display("FAIL short_bad: got %0d want 2", bad_count); end
        load("HE11O WORLD");
        send(0, frame_len, 1);
        vectors++; if (frame_ok !== 1'b1 || good_count !== 16'd4) begin miscompares++; $display("FAIL after_short: got ok=%b good=%0d want 1/4", frame_ok, good_count); end
        vectors++; if (err_code !== 2'd0 || err_idx !== 8'd0) begin miscompares++; $display("FAIL after_short_code: got %0d/%0d want 0/0", err_code, err_idx); end
        @(posedge clk); #1;
    endtask

    task automatic test_long;
        load("HE11O WORLD!!");
        send(0, frame_len, 1);
        vectors++; if (beats_acc !== 13) begin miscompares++; $display("FAIL long_beats: got %0d want 13", beats_acc); end
        vectors++; if (frame_err !== 1'b1 || err_code !== 2'd3 || err_idx !== 8'd11) begin miscompares++; $display("FAIL long_code: got err=%b code=%0d idx=%0d want 1/3/11", frame_err, err_code, err_idx); end
        vectors++; if (bad_count !== 16'd3) begin miscompares++; $display("FAIL long_bad: got %0d want 3", bad_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_last_beat_mismatch;
        load("HE11O WORLX");
        send(0, frame_len, 1);
        vectors++; if (frame_err !== 1'b1 || err_code !== 2'd1 || err_idx !== 8'd10) begin miscompares++; $display("FAIL lastbeat_code: got err=%b code=%0d idx=%0d want 1/1/10", frame_err, err_code, err_idx); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        load("HE11O WORLD");
        send(1, frame_len, 1);
        vectors++; if (beats_acc !== 11) begin miscompares++; $display("FAIL stall_beats: got %0d want 11", beats_acc); end
        vectors++; if (s_lows < 3 || cycles !== 11 + s_lows) begin miscompares++; $display("FAIL stall_cycles: got %0d cycles %0d stalls want 11+stalls with >=3", cycles, s_lows); end
        vectors++; if (s_frame_ok !== 1'b1 || s_good_count !== 16'd1 || s_bad_count !== 16'd0) begin miscompares++; $display("FAIL stall_verdict: got ok=%b good=%0d bad=%0d want 1/1/0", s_frame_ok, s_good_count, s_bad_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame;
        load("HE11O WORLD");
        send(0, 6, 0);
        resetn = 1'b0;
        #1;
        vectors++; if (good_count !== 16'd0 || bad_count !== 16'd0) begin miscompares++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", good_count, bad_count); end
        vectors++; if (frame_ok !== 1'b0 || frame_err !== 1'b0 || tready !== 1'b0) begin miscompares++; $display("FAIL midrst_outs: got ok=%b err=%b rdy=%b want 000", frame_ok, frame_err, tready); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        send(0, frame_len, 1);
        vectors++; if (frame_ok !== 1'b1 || good_count !== 16'd1 || bad_count !== 16'd0) begin miscompares++; $display("FAIL midrst_frame: got ok=%b good=%0d bad=%0d want 1/1/0", frame_ok, good_count, bad_count); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_data_err();
        test_short();
        test_long();
        test_last_beat_mismatch();
        test_stall();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
